ov7670_cfg_seq: RTL and testbench

OV7670_CFG_SEQ -- requirements
Module: ov7670_cfg_seq

---
 rtl/ov7670_pkg.sv | 26 ++
 rtl/ov7670_cfg_rom.sv | 51 +++++
 rtl/ov7670_cfg_seq.sv | 132 +++++++++++++
 tb/tb_ov7670_cfg_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared constants and types for the OV7670 SCCB configuration sequencer.
// Table markers, default camera id, widths and FSM encodings live here.
package ov7670_pkg;

    localparam logic [6:0] C_ID           = 7'h21;
    localparam int         C_NB_ROM_ADDR  = 6;
    localparam int         C_DELAY_ENDCNT = 100000;
    localparam int         C_NB_DELAY_CNT = 17;

    localparam logic [7:0] C_END_MARK     = 8'hFF;
    localparam logic [7:0] C_DELAY_MARK   = 8'hF0;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_REQ      = 3'd3;
    localparam logic [2:0] S_WAIT_FIN = 3'd4;
    localparam logic [2:0] S_DELAY    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_entry_t;

endpackage

// File: rtl/ov7670_cfg_rom.sv
// OV7670 register table: soft reset, settle delay, RGB565 QQVGA setup.
// One-cycle read latency; unused slots read back as the end marker.
module ov7670_cfg_rom
    import ov7670_pkg::*;
#(
    parameter int c_nb_rom_addr = C_NB_ROM_ADDR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [c_nb_rom_addr-1:0] idx_i,
    output cfg_entry_t               entry_o
);

    cfg_entry_t entry_q;

    function automatic cfg_entry_t rom_lut(input int unsigned i);
        case (i)
            0:       return {8'h12, 8'h80};
            1:       return {C_DELAY_MARK, 8'h00};
            2:       return {8'h12, 8'h04};
            3:       return {8'h11, 8'h00};
            4:       return {8'h0C, 8'h04};
            5:       return {8'h3E, 8'h1A};
            6:       return {8'h40, 8'hD0};
            7:       return {8'h8C, 8'h00};
            8:       return {8'h70, 8'h3A};
            9:       return {8'h71, 8'h35};
            10:      return {8'h72, 8'h22};
            11:      return {8'h73, 8'hF2};
            12:      return {8'hA2, 8'h02};
            13:      return {8'h17, 8'h16};
            14:      return {8'h18, 8'h04};
            15:      return {8'h32, 8'hA4};
            16:      return {8'h19, 8'h02};
            17:      return {8'h1A, 8'h7A};
            18:      return {8'h03, 8'h0A};
            default: return {C_END_MARK, C_END_MARK};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= rom_lut(32'(idx_i));
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/ov7670_cfg_seq.sv
// Walks the OV7670 register table, issuing one SCCB write per entry
// and honouring delay entries, until the end marker or the last slot.
module ov7670_cfg_seq
    import ov7670_pkg::*;
#(
    parameter logic [6:0] c_id           = C_ID,
    parameter int         c_nb_rom_addr  = C_NB_ROM_ADDR,
    parameter int         c_delay_endcnt = C_DELAY_ENDCNT,
    parameter int         c_nb_delay_cnt = C_NB_DELAY_CNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_cfg,
    input  logic       sccb_ready,
    input  logic       sccb_finish,
    output logic       start_tx,
    output logic [6:0] id,
    output logic [7:0] addr,
    output logic [7:0] data_wr,
    output logic       busy,
    output logic       cfg_done
);

    localparam logic [c_nb_rom_addr-1:0]  IDX_LAST = '1;
    localparam logic [c_nb_rom_addr-1:0]  IDX_ONE  = c_nb_rom_addr'(1);
    localparam logic [c_nb_delay_cnt-1:0] DLY_LAST =
        c_nb_delay_cnt'(c_delay_endcnt - 1);
    localparam logic [c_nb_delay_cnt-1:0] DLY_ONE  = c_nb_delay_cnt'(1);

    logic [2:0]                state_q, state_d;
    logic [c_nb_rom_addr-1:0]  idx_q, idx_d;
    logic [c_nb_delay_cnt-1:0] dcnt_q, dcnt_d;
    logic [7:0]                addr_q, addr_d;
    logic [7:0]                data_q, data_d;
    logic                      tx_q, tx_d;
    cfg_entry_t                rom_entry;

    ov7670_cfg_rom #(
        .c_nb_rom_addr(c_nb_rom_addr)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .idx_i  (idx_q),
        .entry_o(rom_entry)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tx_d    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_cfg) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_entry == {C_END_MARK, C_END_MARK}) begin
                    state_d = S_DONE;
                end else if (rom_entry.addr == C_DELAY_MARK) begin
                    dcnt_d  = '0;
                    state_d = S_DELAY;
                end else begin
                    addr_d  = rom_entry.addr;
                    data_d  = rom_entry.data;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (sccb_ready) begin
                    tx_d    = 1'b1;
                    state_d = S_WAIT_FIN;
                end
            end
            S_WAIT_FIN: begin
                // The last slot never wraps back to entry 0.
                if (sccb_finish) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DELAY: begin
                if (dcnt_q == DLY_LAST) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_FETCH;
                    end
                end else begin
                    dcnt_d = dcnt_q + DLY_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dcnt_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            tx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign start_tx = tx_q;
    assign id       = c_id;
    assign addr     = addr_q;
    assign data_wr  = data_q;
    assign cfg_done = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Scoreboard bench for ov7670_cfg_seq with a behavioural SCCB slave.
// Expected writes come from the bench's own copy of the register table.
module tb_ov7670_cfg_seq;

    localparam int NDLY = 10;

    localparam logic [15:0] REF_TBL [20] = '{
        16'h1280, 16'hF000, 16'h1204, 16'h1100, 16'h0C04,
        16'h3E1A, 16'h40D0, 16'h8C00, 16'h703A, 16'h7135,
        16'h7222, 16'h73F2, 16'hA202, 16'h1716, 16'h1804,
        16'h32A4, 16'h1902, 16'h1A7A, 16'h030A, 16'hFFFF
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_cfg = 1'b0;
    logic       sccb_finish = 1'b0;
    logic       model_rdy = 1'b1;
    logic       hold_ready = 1'b0;
    logic       sccb_ready;
    logic       start_tx;
    logic [6:0] id;
    logic [7:0] addr;
    logic [7:0] data_wr;
    logic       busy;
    logic       cfg_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tx_count = 0;
    bit rand_lat = 1'b0;

    logic [15:0] exp_q [$];
    int          tx_cyc [$];
    int          fin_cyc [$];

    assign sccb_ready = model_rdy & ~hold_ready;

    ov7670_cfg_seq #(
        .c_id          (7'h21),
        .c_nb_rom_addr (6),
        .c_delay_endcnt(NDLY),
        .c_nb_delay_cnt(17)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_cfg  (start_cfg),
        .sccb_ready (sccb_ready),
        .sccb_finish(sccb_finish),
        .start_tx   (start_tx),
        .id         (id),
        .addr       (addr),
        .data_wr    (data_wr),
        .busy       (busy),
        .cfg_done   (cfg_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: every table entry up to the end marker that is not a delay.
    task automatic push_run(output int n);
        logic [15:0] e;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            e = (i < 20) ? REF_TBL[i] : 16'hFFFF;
            if (e == 16'hFFFF) break;
            if (e[15:8] != 8'hF0) begin
                exp_q.push_back(e);
                n++;
            end
        end
    endtask

    task automatic start_run(output int n);
        push_run(n);
        tx_cyc.delete();
        fin_cyc.delete();
        tx_count = 0;
        @(posedge clk); #1;
        start_cfg = 1'b1;
        @(posedge clk); #1;
        start_cfg = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string nm);
        int k = 0;
        while (tx_count < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        chk(nm, 32'(tx_count >= n), 1);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (cfg_done !== 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(cfg_done), 1);
    endtask

    // SCCB slave: busy after start_tx, finish pulse after a latency.
    initial begin
        int  cnt;
        bit  act;
        cnt = 0;
        act = 1'b0;
        forever begin
            @(posedge clk); #1;
            sccb_finish = 1'b0;
            if (!rst_n) begin
                act = 1'b0;
                cnt = 0;
                model_rdy = 1'b1;
            end else if (start_tx) begin
                act = 1'b1;
                cnt = rand_lat ? int'($urandom_range(20, 120)) : 100;
                model_rdy = 1'b0;
            end else if (act) begin
                cnt--;
                if (cnt == 0) begin
                    sccb_finish = 1'b1;
                    act = 1'b0;
                    model_rdy = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every start_tx.
    initial begin
        logic [7:0]  a_q;
        logic [7:0]  d_q;
        logic [15:0] e;
        bit          in_tx;
        bit          stab_ok;
        bit          prev_tx;
        a_q = '0;
        d_q = '0;
        in_tx = 1'b0;
        stab_ok = 1'b1;
        prev_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_tx = 1'b0;
                prev_tx = 1'b0;
            end else begin
                if (start_tx && prev_tx) begin
                    chk("tx_one_cycle", 1, 0);
                end else if (start_tx) begin
                    tx_count++;
                    tx_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tx", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_addr", 32'(addr), 32'(e[15:8]));
                        chk("tx_data", 32'(data_wr), 32'(e[7:0]));
                    end
                    chk("tx_id", 32'(id), 32'h21);
                    chk("tx_busy", 32'(busy), 1);
                    a_q = addr;
                    d_q = data_wr;
                    in_tx = 1'b1;
                    stab_ok = 1'b1;
                end else if (in_tx) begin
                    if (addr !== a_q || data_wr !== d_q) stab_ok = 1'b0;
                end
                if (sccb_finish) begin
                    fin_cyc.push_back(cyc);
                    if (in_tx) begin
                        chk("hold_stable", 32'(stab_ok), 1);
                        in_tx = 1'b0;
                    end
                end
                prev_tx = start_tx;
            end
        end
    end

    initial begin
        int nw;
        int gap;
        int rise;
        int base;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_start_tx", 32'(start_tx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_done", 32'(cfg_done), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data", 32'(data_wr), 0);
        chk("rst_id", 32'(id), 32'h21);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Run 1: fixed 100-cycle finish latency, delay entry timing.
        start_run(nw);
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 1);
        wait_tx(2, "wait_tx2");
        if (tx_cyc.size() >= 2 && fin_cyc.size() >= 1) begin
            gap = tx_cyc[1] - fin_cyc[0];
            chk("delay_gap_min", 32'(gap >= NDLY + 3), 1);
            chk("delay_gap_max", 32'(gap <= NDLY + 10), 1);
        end
        wait_done("run1_done");
        chk("run1_tx_count", tx_count, nw);
        chk("run1_busy", 32'(busy), 0);
        chk("run1_queue", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        chk("done_held", 32'(cfg_done), 1);

        // Run 2: ready withheld, then start_cfg during WAIT_FIN.
        rand_lat = 1'b1;
        hold_ready = 1'b1;
        start_run(nw);
        repeat (50) @(posedge clk);
        chk("hold_no_tx", tx_count, 0);
        chk("hold_cfg_done", 32'(cfg_done), 0);
        @(posedge clk); #1;
        hold_ready = 1'b0;
        rise = cyc;
        wait_tx(1, "wait_tx_ready");
        if (tx_cyc.size() >= 1) chk("tx_after_ready", tx_cyc[0], rise + 1);
        wait_tx(3, "wait_tx3");
        repeat (2) @(posedge clk); #1;
        start_cfg = 1'b1;
        @(posedge clk); #1;
        start_cfg = 1'b0;
        @(negedge clk);
        chk("ignored_start_busy", 32'(busy), 1);
        wait_done("run2_done");
        chk("run2_tx_count", tx_count, nw);
        chk("run2_queue", exp_q.size(), 0);

        // Run 3: reset asserted while a write is outstanding.
        start_run(nw);
        wait_tx(2, "wait_tx_rst");
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start_tx", 32'(start_tx), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cfg_done", 32'(cfg_done), 0);
        chk("mid_rst_addr", 32'(addr), 0);
        chk("mid_rst_data", 32'(data_wr), 0);
        exp_q.delete();
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        base = tx_count;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("post_rst_no_tx", tx_count, base);
        chk("post_rst_busy", 32'(busy), 0);

        // Run 4: full sequence after reset restarts at entry 0.
        start_run(nw);
        wait_done("run4_done");
        chk("run4_tx_count", tx_count, nw);
        chk("run4_busy", 32'(busy), 0);
        chk("run4_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
